// File: rtl/mem_port_arbiter4_pkg.sv
// Shared definitions for the four-way data-memory port arbiter:
// FSM state encoding, requester count, master indices and a one-hot helper.
package mem_port_arbiter4_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ = 4;

    localparam logic [1:0] IFETCH = 2'd0;
    localparam logic [1:0] LSU    = 2'd1;
    localparam logic [1:0] AUX0   = 2'd2;
    localparam logic [1:0] AUX1   = 2'd3;

    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mem_port_arbiter4_rr_pick4.sv
// Combinational round-robin pick over four requests.
// Ports: req[3:0], ptr[1:0] in; winner[1:0] (first set bit from ptr), any out.
module rr_pick4
    import mem_port_arbiter4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic [1:0]       winner,
    output logic             any
);

    logic [1:0] idx;

    // Scan from the farthest offset down so the nearest set bit wins.
    always_comb begin
        winner = ptr;
        idx    = ptr;
        any    = |req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter4.sv
// Round-robin arbiter for the shared data-memory port with a grant watchdog.
// Ports: clk, reset, req[3:0], done in; gnt[3:0], sel[1:0], bus_valid, timeout, err_id[1:0] out.
module mem_port_arbiter4
    import mem_port_arbiter4_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CW      = $clog2(TIMEOUT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       sel,
    output logic             bus_valid,
    output logic             timeout,
    output logic [1:0]       err_id
);

    state_t     state;
    state_t     state_nx;
    logic [1:0] ptr;
    logic [CW-1:0] cnt;
    logic [1:0] winner;
    logic       any;
    logic       expire;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    assign expire = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any)            state_nx = GRANT;
            GRANT:   if (done || expire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode only flops, so no path exists from req/done.
    always_comb begin
        bus_valid = (state == GRANT);
        gnt       = bus_valid ? onehot4(sel) : '0;
    end

    // done takes priority over watchdog expiry, suppressing the pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel     <= 2'd0;
            ptr     <= 2'd0;
            cnt     <= '0;
            timeout <= 1'b0;
            err_id  <= 2'd0;
        end else begin
            timeout <= 1'b0;
            if (state == IDLE) begin
                if (any) begin
                    sel <= winner;
                    cnt <= '0;
                end
            end else if (done) begin
                ptr <= sel + 2'd1;
            end else if (expire) begin
                ptr     <= sel + 2'd1;
                timeout <= 1'b1;
                err_id  <= sel;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter4.sv
// Directed bench for mem_port_arbiter4 with a transaction-level reference model.
// Compares every output each cycle and pins the model with literal expectations.
module tb_mem_port_arbiter4;

    localparam int TO = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic       done  = 1'b0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       bus_valid;
    logic       timeout;
    logic [1:0] err_id;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter4 #(
        .TIMEOUT (TO),
        .CW      ($clog2(TO))
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .sel       (sel),
        .bus_valid (bus_valid),
        .timeout   (timeout),
        .err_id    (err_id)
    );

    always #5 clk = ~clk;

    // Reference: who owns the port, for how many cycles, and where the
    // next search starts.
    bit m_busy;
    bit m_to;
    int m_owner;
    int m_age;
    int m_ptr;
    int m_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  = 0;
            m_to    = 0;
            m_owner = 0;
            m_age   = 0;
            m_ptr   = 0;
            m_err   = 0;
        end else begin
            m_to = 0;
            if (m_busy) begin
                if (done) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % 4;
                end else if (m_age == TO) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % 4;
                    m_to   = 1;
                    m_err  = m_owner;
                end else begin
                    m_age++;
                end
            end else if (req != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_ptr + k) % 4;
                    if (!m_busy && req[i]) begin
                        m_busy  = 1;
                        m_owner = i;
                        m_age   = 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("m_gnt", int'(gnt), m_busy ? (1 << m_owner) : 0);
            chk("m_sel", int'(sel), m_owner);
            chk("m_bus_valid", int'(bus_valid), int'(m_busy));
            chk("m_timeout", int'(timeout), int'(m_to));
            chk("m_err_id", int'(err_id), m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(input string name, input int exp_sel,
                              output int n);
        n = 0;
        while (!bus_valid && n < 10) begin
            tick();
            n++;
        end
        chk({name, "_bv"}, int'(bus_valid), 1);
        chk({name, "_sel"}, int'(sel), exp_sel);
    endtask

    task automatic release_after(input int hold);
        repeat (hold) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("rel_bv", int'(bus_valid), 0);
        chk("rel_gnt", int'(gnt), 0);
    endtask

    initial begin
        int n;
        int order [5];
        order = '{0, 1, 2, 3, 0};

        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_bv", int'(bus_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_err", int'(err_id), 0);

        req = 4'b0001;
        tick();
        chk("t1_gnt", int'(gnt), 1);
        chk("t1_sel", int'(sel), 0);
        chk("t1_bv", int'(bus_valid), 1);
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0000;
        chk("t1_rel_gnt", int'(gnt), 0);
        chk("t1_rel_bv", int'(bus_valid), 0);

        req = 4'b1001;
        wait_grant("wrap_first", 3, n);
        release_after(1);
        wait_grant("wrap_next", 0, n);
        chk("wrap_gap", n, 1);
        release_after(1);
        req = 4'b0000;

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant("rr", order[g], n);
            if (g > 0) chk("rr_gap", n, 1);
            release_after(2);
        end
        req = 4'b0000;
        tick();

        req = 4'b0100;
        wait_grant("wd", 2, n);
        n = 0;
        while (bus_valid && n < 20) begin
            n++;
            tick();
        end
        chk("wd_len", n, TO);
        chk("wd_pulse", int'(timeout), 1);
        chk("wd_err", int'(err_id), 2);
        req = 4'b1111;
        tick();
        chk("wd_pulse_end", int'(timeout), 0);
        chk("wd_next_bv", int'(bus_valid), 1);
        chk("wd_next_sel", int'(sel), 3);
        release_after(1);
        req = 4'b0000;
        tick();

        req = 4'b0001;
        wait_grant("race", 0, n);
        repeat (TO - 1) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0000;
        chk("race_bv", int'(bus_valid), 0);
        chk("race_timeout", int'(timeout), 0);
        chk("race_err", int'(err_id), 2);
        tick();
        chk("race_timeout2", int'(timeout), 0);

        req = 4'b0010;
        wait_grant("arst_pre", 1, n);
        tick();
        #4;
        reset = 1'b1;
        #1;
        chk("arst_gnt", int'(gnt), 0);
        chk("arst_sel", int'(sel), 0);
        chk("arst_bv", int'(bus_valid), 0);
        #1;
        reset = 1'b0;
        req   = 4'b0100;
        tick();
        wait_grant("arst_post", 2, n);
        release_after(1);
        req = 4'b0000;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter4.md
# mem_port_arbiter4

Round-robin arbiter sharing the single data-memory port among four requesters: instruction fetch, load/store, and two auxiliary masters. It grants one requester at a time, holds the grant until the memory signals completion or a watchdog expires, and drives the 2-bit select of the 4-input address/write-data mux in front of the port. It sits between the pipeline masters and the memory interface.

## Interface
- TIMEOUT, 64, cycles a grant may stay open without `done` before forced release; must be ≥ 2.
- CW, $clog2(TIMEOUT), width of the watchdog counter.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req  input  4  request per master, bit i = master i; level-sensitive.
- done  input  1  one-cycle pulse from memory, ending the current transaction.
- gnt  output  4  registered one-hot grant; all zero when idle.
- sel  output  2  registered mux select = index of the granted master; holds its last value when idle.
- bus_valid  output  1  high exactly while a grant is open.
- timeout  output  1  one-cycle pulse on forced release.
- err_id  output  2  index of the master whose grant last timed out.

## Operation
- Clock is `clk`; reset is `reset`, asynchronous and active-high.
- State machine with two states:
  - IDLE: bus_valid=0, gnt=0.
  - GRANT: bus_valid=1, gnt=onehot(sel).
- IDLE → GRANT on any `req` bit set.
  - Winner is the first set bit searching from `ptr`, then ptr+1, ptr+2, ptr+3 (mod 4).
  - On the transition, load `sel` = winner and clear the watchdog counter.
- GRANT → IDLE on `done`, or when the watchdog counter reaches TIMEOUT-1 without `done`.
  - Either way, `ptr` ← sel+1 (mod 4, wraps 3→0).
- In GRANT the counter increments by 1 each cycle. `req` changes are ignored: a master dropping `req` does not cancel its grant. Masters must hold `req` until `done`.
- Timeout release: `timeout`=1 for one cycle, coincident with the cycle in which the FSM is back in IDLE. `err_id` ← sel.
- `done` and watchdog expiry in the same cycle: `done` wins, no timeout pulse.
- `done` while in IDLE: ignored.
- Reset values: state IDLE, gnt=0, sel=0, bus_valid=0, timeout=0, err_id=0, ptr=0, counter=0.
- Reset mid-grant: grant drops asynchronously. The transaction is abandoned and no timeout is flagged.

## Timing
- Grant latency: request sampled at edge k in IDLE → gnt/sel/bus_valid valid after edge k.
- Release: `done` sampled at edge m → gnt=0, bus_valid=0 after edge m.
- One mandatory IDLE turnaround cycle between grants. The earliest next grant appears after edge m+1.
- Maximum grant length is TIMEOUT cycles of bus_valid. The timeout pulse is visible after the edge that ends the grant.
- All outputs are registered; there is no combinational path from `req` or `done` to any output.

## Structure
- Shared package holds the state encoding (IDLE=1'b0, GRANT=1'b1), N_REQ=4, and the master index constants (IFETCH=0, LSU=1, AUX0=2, AUX1=3).
- Sub-module `rr_pick4`: combinational, takes req[3:0] and ptr[1:0], returns winner[1:0] and any.

## Test plan
- Reset, then req=4'b0001 at cycle 2 → after the next edge gnt=0001, sel=0, bus_valid=1; `done` at cycle 5 → gnt=0 after that edge, ptr=1.
- req=4'b1111 held throughout, `done` 3 cycles after each grant → grant order sel=0,1,2,3,0 with one idle cycle between grants.
- req=4'b1001 with ptr=1 → master 3 granted first; after its `done`, ptr wraps to 0 and master 0 is granted next.
- Grant master 2, never assert `done`, TIMEOUT=8 → bus_valid high exactly 8 cycles, then a one-cycle timeout pulse, err_id=2, next grant starts from master 3.
- `done` on the same cycle as watchdog expiry → release with timeout=0; err_id unchanged.
- Assert reset asynchronously mid-grant (between edges) → gnt, sel, bus_valid, ptr go to 0 immediately; after reset release, req=0100 is granted with sel=2.
